// File: rtl/lmsm_sequencer.sv
// LM/SM expander: turns a load/store-multiple in IF_ID into one single-register
// memory micro-op per cycle for the ID_RR path, holding fetch/decode meanwhile.
module lmsm_sequencer #(
    parameter logic [3:0] LM_OPCODE = 4'b0110,
    parameter logic [3:0] SM_OPCODE = 4'b0111,
    parameter int         ADDR_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] id_ir,
    input  logic        id_valid,
    input  logic        stall_in,
    input  logic        flush,
    output logic        if_id_hold,
    output logic        uop_valid,
    output logic        uop_is_load,
    output logic        uop_is_store,
    output logic [2:0]  uop_reg,
    output logic [2:0]  uop_base,
    output logic [15:0] uop_offset,
    output logic        uop_last,
    output logic        busy
);

    typedef enum logic {S_IDLE, S_SEQ} state_t;

    state_t      r_state,    w_state_nxt;
    logic [7:0]  r_rem_mask, w_rem_nxt;
    logic [3:0]  r_idx,      w_idx_nxt;
    logic [2:0]  r_base,     w_base_nxt;
    logic        r_is_ld,    w_is_ld_nxt;

    logic [3:0]  w_opcode;
    logic [2:0]  w_ra;
    logic [7:0]  w_mask;
    logic        w_detect;
    logic        w_in_seq;
    logic [2:0]  w_first_reg;
    logic        w_single;
    logic        w_hold;
    logic [15:0] w_offset;

    assign w_opcode = id_ir[15:12];
    assign w_ra     = id_ir[11:9];
    assign w_mask   = id_ir[7:0];
    assign w_detect = id_valid && ((w_opcode == LM_OPCODE) || (w_opcode == SM_OPCODE))
                      && (w_mask != 8'd0);
    assign w_in_seq = (r_state == S_SEQ);

    // mask[7-k] selects Rk; scanning downward leaves the lowest set Rk.
    always_comb begin
        w_first_reg = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (r_rem_mask[7-k]) w_first_reg = 3'(k);
        end
    end

    assign w_single = (r_rem_mask != 8'd0) && ((r_rem_mask & (r_rem_mask - 8'd1)) == 8'd0);
    assign w_offset = 16'(32'(r_idx) * ADDR_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rem_mask <= 8'd0;
            r_idx      <= 4'd0;
            r_base     <= 3'd0;
            r_is_ld    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rem_mask <= w_rem_nxt;
            r_idx      <= w_idx_nxt;
            r_base     <= w_base_nxt;
            r_is_ld    <= w_is_ld_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem_mask;
        w_idx_nxt   = r_idx;
        w_base_nxt  = r_base;
        w_is_ld_nxt = r_is_ld;
        w_hold      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    w_rem_nxt = 8'd0;
                    w_idx_nxt = 4'd0;
                end else if (w_detect) begin
                    w_state_nxt = S_SEQ;
                    w_rem_nxt   = w_mask;
                    w_idx_nxt   = 4'd0;
                    w_base_nxt  = w_ra;
                    w_is_ld_nxt = (w_opcode == LM_OPCODE);
                    w_hold      = 1'b1;
                end
            end
            S_SEQ: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                    w_rem_nxt   = 8'd0;
                    w_idx_nxt   = 4'd0;
                end else begin
                    // Release IF_ID one cycle early so the next instruction lands as the last uop issues.
                    w_hold = !(w_single && !stall_in);
                    if (!stall_in) begin
                        w_rem_nxt[3'd7 - w_first_reg] = 1'b0;
                        w_idx_nxt = r_idx + 4'd1;
                        if (w_single) begin
                            w_state_nxt = S_IDLE;
                            w_rem_nxt   = 8'd0;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Hold is gated by reset so every output reads 0 while reset is asserted.
    assign if_id_hold   = w_hold && rst_n;
    assign uop_valid    = w_in_seq && !flush;
    assign uop_is_load  = w_in_seq && r_is_ld;
    assign uop_is_store = w_in_seq && !r_is_ld;
    assign uop_reg      = w_in_seq ? w_first_reg : 3'd0;
    assign uop_base     = w_in_seq ? r_base : 3'd0;
    assign uop_offset   = w_in_seq ? w_offset : 16'd0;
    assign uop_last     = w_in_seq && w_single;
    assign busy         = w_in_seq;

endmodule

// File: doc/lmsm_sequencer.md
Name: lmsm_sequencer

Overview:
- Expands LM (load multiple) and SM (store multiple) instructions sitting in the IF_ID register into one single-register memory micro-op per cycle.
- Micro-ops are injected into the ID_RR path.
- While expanding, the block holds IF and IF_ID (drives the fetch/decode stall).
- Sits between the decode control logic and the ID_RR pipeline register; replaces the single-flag SM handling with a full sequencer.

Parameters:
- LM_OPCODE, 4'b0110, opcode decoded as load-multiple.
- SM_OPCODE, 4'b0111, opcode decoded as store-multiple.
- ADDR_STEP, 1, address increment per transferred register (word-addressed memory).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_ir  in  16  instruction in IF_ID: [15:12] opcode, [11:9] base register RA, [7:0] register mask.
- id_valid  in  1  id_ir holds a valid instruction.
- stall_in  in  1  downstream hazard stall; freezes micro-op issue.
- flush  in  1  pipeline flush (branch/jump redirect).
- if_id_hold  out  1  hold PC and IF_ID (used as inverse of ID_RR enable for normal decode).
- uop_valid  out  1  micro-op fields valid; ID_RR mux selects the sequencer.
- uop_is_load  out  1  micro-op is a register load (LM).
- uop_is_store  out  1  micro-op is a register store (SM).
- uop_reg  out  3  data register for this transfer.
- uop_base  out  3  base address register RA.
- uop_offset  out  16  address offset = index × ADDR_STEP.
- uop_last  out  1  final micro-op of the instruction.
- busy  out  1  sequencer in SEQ state.

Behaviour:
- Mask mapping: mask[7-k] selects Rk. Issue order is R0 first (lowest index first). Offsets are compacted: the i-th transferred register (i = 0..7) gets offset i × ADDR_STEP, zero-extended to 16 bits.
- State: FSM {IDLE, SEQ}, plus registers rem_mask[7:0], idx[3:0], base[2:0], is_ld.
- Reset (rst_n low, async): state=IDLE, rem_mask=0, idx=0, base=0, is_ld=0. All outputs read 0.
- detect = id_valid & (opcode==LM_OPCODE | opcode==SM_OPCODE) & mask!=0.
- IDLE:
  - if detect & !flush: latch rem_mask=mask, base=RA, is_ld=(opcode==LM_OPCODE), idx=0; go to SEQ.
  - if_id_hold = detect & !flush (combinational) in this acceptance cycle T0.
  - uop_valid=0.
- LM/SM with mask==0: not accepted; no micro-op, no hold. Passes through as a NOP.
- Non-LM/SM opcodes are ignored entirely.
- SEQ (outputs combinational from registers):
  - uop_valid = !flush.
  - uop_reg = index of first set bit of rem_mask.
  - uop_last = (popcount(rem_mask)==1).
  - uop_is_load = is_ld; uop_is_store = !is_ld; uop_base = base; uop_offset = idx × ADDR_STEP.
  - busy=1.
  - Advance on !stall_in & !flush: clear the issued bit, idx+1. If uop_last: go to IDLE, rem_mask=0.
  - if_id_hold = !(uop_last & !stall_in) & !flush.
- Latency: first micro-op appears at T1, one cycle after acceptance. N set bits give N micro-ops at T1..TN when unstalled. if_id_hold is high for T0..T(N-1) and low at TN, so the next instruction loads into IF_ID at the TN edge.
- stall_in in SEQ: the current micro-op is held with identical fields; idx and rem_mask are unchanged; hold stays 1.
- stall_in in IDLE: acceptance still occurs; the first micro-op waits for stall release.
- flush: synchronous, highest priority over accept and advance. In the same cycle uop_valid=0 and if_id_hold=0. Next state=IDLE, rem_mask=0, idx=0.
- id_ir is ignored while in SEQ, even if it changes.
- Async reset mid-sequence aborts immediately; outputs go to 0 without waiting for a clock.

Test Plan:
1. LM, RA=R1, mask 8'hA0 -> T0 hold=1. T1: uop_valid=1, reg=0, offset=0, load=1, base=1, last=0. T2: reg=2, offset=1, last=1, hold=0. T3: IDLE, uop_valid=0.
2. SM, RA=R7, mask 8'hFF -> 8 consecutive micro-ops R0..R7 with offsets 0..7, store=1, last only on R7, hold high for exactly 8 cycles.
3. LM mask 8'h11 (R3,R7) with stall_in high for 3 cycles at T1 -> reg=3, offset=0 held for 3 cycles, then reg=7, offset=1, last=1 on release.
4. SM mask 8'h00 and ADD opcode 4'b0001 -> uop_valid, hold and busy all stay 0; state stays IDLE.
5. LM mask 8'hF0, flush asserted at T2 -> uop_valid=0 and hold=0 at T2; busy=0 at T3; next LM is accepted normally.
6. rst_n pulled low mid-sequence (between clock edges) -> all outputs 0 immediately. After release, state is IDLE and a new SM starts from idx=0.
